keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad and reports debounced key presses as a 4-bit code with a one-cycle valid strobe. It is the input-side counterpart of the multiplexed seven-segment display driver: the display drives a digit select and segment bus, while this block drives the column lines and reads the row lines back. Its outputs feed the operand and mode registers in the calculator top level, in place of raw slide switches and buttons.

## Interface
Parameters:
- SCAN_DIV, default 1000: clock cycles each column is held active. Must be at least 4.
- DEBOUNCE_CNT, default 4: number of consecutive matching frames required to accept a press or a release. Must be at least 1.

Ports:
- CLK  input  1  system clock; single clock domain.
- RST  input  1  synchronous, active-high reset.
- Row  input  4  keypad rows; active-low with external pull-ups; asynchronous to CLK.
- Col  output 4  column drive; active-low, exactly one bit low at any time.
- Key_code  output 4  accepted key, encoded as row*4 + col; holds its value until the next accept.
- Key_valid  output 1  one-cycle pulse when a key is accepted.
- Key_held  output 1  high from accept until release is accepted.

## Operation
- Row passes through a 2-flop synchronizer before any use.
- Column scan:
  - A slot counter counts 0..SCAN_DIV-1.
  - At terminal count, Col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Synchronized rows are sampled on the last cycle of each slot into bits [col*4 +: 4] of a 16-bit frame snapshot. A pressed key reads as 1.
  - One frame is 4*SCAN_DIV cycles and ends at the column 3 terminal count.
- Frame evaluation at each frame end:
  - If snapshot == previous snapshot, the stable counter increments, saturating at DEBOUNCE_CNT.
  - Otherwise the stable counter resets to 0.
  - The previous snapshot is then updated.
- State machine:
  - IDLE: when the stable counter reaches DEBOUNCE_CNT with exactly one bit set in the snapshot:
    - Key_code <= index of that bit.
    - Key_valid pulses.
    - Move to PRESSED.
  - IDLE: a snapshot with zero bits set, or two or more bits set (ghosting/multi-press), is never accepted. Stay in IDLE.
  - PRESSED: when the stable counter reaches DEBOUNCE_CNT with an all-zero snapshot, move to IDLE and clear Key_held.
  - PRESSED: any other stable snapshot, including a second key or a changed key, keeps the state in PRESSED. There is no auto-repeat.
- Key_held is 1 exactly in PRESSED.
- Reset values:
  - Col = 1110.
  - Key_code = 0, Key_valid = 0, Key_held = 0.
  - State IDLE.
  - Slot counter, stable counter, both snapshots and synchronizer flops all 0.

## Timing
- Key_valid and Key_code are registered. Both update in the cycle after the frame-end evaluation.
- Accept latency with a clean press held from before a frame start: DEBOUNCE_CNT+1 full frames, plus 1 cycle.
- Release latency is the same, measured from the first frame that is fully released.
- A press shorter than (DEBOUNCE_CNT+1) frames produces no Key_valid.
- Bounce mid-frame: any sample differing from the prior frame resets the stable counter. Acceptance requires uninterrupted agreement.
- RST asserted mid-scan or in PRESSED: all state returns to reset values on the next edge, with no Key_valid pulse. A key still held after reset is re-accepted through the full IDLE path.
- Slot counter wrap and frame wrap are free-running and never stall.

## Structure
- Shared package keypad_pkg:
  - State enum {IDLE, PRESSED}.
  - COL_INIT = 4'b1110.
  - Function popcount16 / onehot-to-index for the 16-bit snapshot.
- Sub-module keypad_col_scan owns the slot counter, Col rotation, row synchronizer and snapshot assembly. It outputs the frame snapshot plus a frame_done strobe.
- The top module owns the debounce counter, the FSM and the outputs.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=2, so one frame is 16 cycles.
- Reset: RST high for 2 cycles -> Col=1110, Key_valid=0, Key_held=0, Key_code=0. Col then rotates every 4 cycles in the sequence 1110, 1101, 1011, 0111.
- Clean press:
  - Stimulus: model key row 2 / col 1, asserted before frame 0.
  - Response: exactly one Key_valid pulse, 1 cycle after the frame-2 end (cycle 49 from frame 0 start), with Key_code=9 and Key_held=1.
- Release:
  - Stimulus: release that key at a frame boundary.
  - Response: Key_held drops 3 frames + 1 cycle later; no Key_valid pulse.
- Bounce:
  - Stimulus: key 5 toggled every 10 cycles for 60 cycles, then held.
  - Response: no Key_valid during the bounce; a single pulse with Key_code=5 exactly 3 frames + 1 cycle after the last toggle frame.
- Multi-key:
  - Stimulus: keys 0 and 15 both held from IDLE.
  - Response: no Key_valid and Key_held stays 0. After key 15 is released, key 0 is accepted with Key_code=0.
- Reset mid-operation:
  - Stimulus: assert RST while in PRESSED with key 3 still held.
  - Response: outputs return to reset values. Key_valid re-pulses with Key_code=3 after 3 frames + 1 cycle from RST deassert.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
//   state_t        - accept FSM states
//   COL_INIT       - column drive after reset (column 0 active, active-low)
//   popcount16     - number of set bits in a 16-bit frame snapshot
//   onehot_to_code - converts a one-hot snapshot into a key code
package keypad_pkg;

  typedef enum logic {IDLE, PRESSED} state_t;

  localparam logic [3:0] COL_INIT = 4'b1110;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Snapshot bits are laid out column-major (bit = col*4 + row) because a
  // whole column of rows is captured at once. Key codes are row-major
  // (row*4 + col), so the two index fields are swapped on the way out.
  function automatic logic [3:0] onehot_to_code(input logic [15:0] v);
    logic [3:0] code;
    logic [3:0] bit_idx;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      bit_idx = 4'(i);
      if (v[i]) code = {bit_idx[1:0], bit_idx[3:2]};
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column scanner and frame assembler.
//   clk, rst    - system clock, synchronous active-high reset
//   row         - raw active-low keypad rows (asynchronous)
//   col         - active-low column drive, one bit low at a time
//   snapshot    - full 16-bit frame (1 = pressed), valid while frame_done
//   frame_done  - strobe on the last cycle of column 3's slot
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] snapshot,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic [11:0]   frame_buf;
  logic          slot_end;

  assign slot_end   = (slot_cnt == CW'(SCAN_DIV - 1));
  assign frame_done = slot_end && (col_idx == 2'd3);
  // Column 3 is never stored: it is taken straight from the synchronizer
  // on the frame-end cycle so the frame is complete exactly at frame_done.
  assign snapshot   = {~row_s2, frame_buf};

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      col       <= COL_INIT;
      col_idx   <= '0;
      row_s1    <= '0;
      row_s2    <= '0;
      frame_buf <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (slot_end) begin
        slot_cnt <= '0;
        col      <= {col[2:0], col[3]};
        col_idx  <= col_idx + 2'd1;
        // Sampling at slot end leaves at least two cycles for the new
        // column's rows to settle through the synchronizer.
        case (col_idx)
          2'd0:    frame_buf[3:0]  <= ~row_s2;
          2'd1:    frame_buf[7:4]  <= ~row_s2;
          2'd2:    frame_buf[11:8] <= ~row_s2;
          default: ;
        endcase
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce.
//   CLK, RST   - system clock, synchronous active-high reset
//   Row        - active-low keypad rows (external pull-ups, asynchronous)
//   Col        - active-low column drive
//   Key_code   - last accepted key (row*4 + col), held until next accept
//   Key_valid  - one-cycle strobe on accept
//   Key_held   - high while a key is accepted and not yet released
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Key_code,
  output logic       Key_valid,
  output logic       Key_held
);

  localparam int              SW         = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(DEBOUNCE_CNT);

  logic [15:0]   snapshot, prev_snap;
  logic          frame_done, eval_q, stable_ok;
  logic [SW-1:0] stable_cnt;
  state_t        state, next_state;
  logic [3:0]    code_d;
  logic          valid_d;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (CLK),
    .rst        (RST),
    .row        (Row),
    .col        (Col),
    .snapshot   (snapshot),
    .frame_done (frame_done)
  );

  // Debounce: counts consecutive identical frames. The FSM acts one cycle
  // later (eval_q) when prev_snap holds the frame just evaluated.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_snap  <= '0;
      stable_cnt <= '0;
      eval_q     <= 1'b0;
      state      <= IDLE;
      Key_code   <= '0;
      Key_valid  <= 1'b0;
    end else begin
      eval_q <= frame_done;
      if (frame_done) begin
        prev_snap <= snapshot;
        if (snapshot == prev_snap) begin
          if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + SW'(1);
        end else begin
          stable_cnt <= '0;
        end
      end
      state     <= next_state;
      Key_code  <= code_d;
      Key_valid <= valid_d;
    end
  end

  assign stable_ok = eval_q && (stable_cnt == STABLE_MAX);
  assign Key_held  = (state == PRESSED);

  always_comb begin
    next_state = state;
    code_d     = Key_code;
    valid_d    = 1'b0;
    case (state)
      IDLE: begin
        // Zero or multiple bits (ghosting) never produce an accept.
        if (stable_ok && popcount16(prev_snap) == 5'd1) begin
          code_d     = onehot_to_code(prev_snap);
          valid_d    = 1'b1;
          next_state = PRESSED;
        end
      end
      PRESSED: begin
        // Only a stable all-released frame leaves; no auto-repeat.
        if (stable_ok && prev_snap == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int FRAME = 16;
  localparam int LAT   = 49;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys = '0;

  int cyc = 0;
  int nchecks = 0;
  int nerr = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [3:0] col_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .CLK       (clk),
    .RST       (rst),
    .Row       (row),
    .Col       (col),
    .Key_code  (key_code),
    .Key_valid (key_valid),
    .Key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Cycle index within the scan: 0 on the first cycle with slot 0 of column 0.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Keypad matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
  end

  // Scoreboard: every Key_valid pulse must match the head of the queue.
  always @(negedge clk) begin
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        nchecks++; nerr++;
        $display("FAIL unexpected_valid: cyc=%0d code=%0d, none expected", cyc, key_code);
      end else begin
        e = exp_q.pop_front();
        nchecks += 2;
        if (cyc !== e.cyc) begin
          nerr++;
          $display("FAIL valid_cycle: got cyc=%0d want %0d", cyc, e.cyc);
        end
        if (key_code !== e.code) begin
          nerr++;
          $display("FAIL valid_code: got %0d want %0d", key_code, e.code);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_frame_start();
    do step(1); while (cyc % FRAME != 0);
  endtask

  task automatic push_exp(input int c, input logic [3:0] code);
    exp_t x;
    x.cyc = c; x.code = code;
    exp_q.push_back(x);
  endtask

  task automatic check_queue_empty(input string name);
    nchecks++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s_missing_valid: %0d pulses outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_held(input string name, input logic want);
    nchecks++;
    if (key_held !== want) begin
      nerr++;
      $display("FAIL %s_held: got %b want %b at cyc=%0d", name, key_held, want, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    nchecks += 4;
    if (col !== 4'b1110) begin nerr++; $display("FAIL reset_col: got %b want 1110", col); end
    if (key_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_held !== 1'b0) begin nerr++; $display("FAIL reset_held: got %b want 0", key_held); end
    if (key_code !== 4'd0) begin nerr++; $display("FAIL reset_code: got %0d want 0", key_code); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nchecks++;
      if (col !== col_pat[(cyc / 4) % 4]) begin
        nerr++;
        $display("FAIL col_rotate: cyc=%0d got %b want %b", cyc, col, col_pat[(cyc / 4) % 4]);
      end
      step(1);
    end
  endtask

  task automatic test_clean_press();
    int t0;
    to_frame_start();
    t0 = cyc;
    keys[9] = 1'b1;
    push_exp(t0 + LAT, 4'd9);
    step(LAT - 1);
    check_held("press_early", 1'b0);
    step(11);
    check_held("press", 1'b1);
    nchecks++;
    if (key_code !== 4'd9) begin nerr++; $display("FAIL press_code: got %0d want 9", key_code); end
    check_queue_empty("press");
  endtask

  task automatic test_release();
    int t0;
    to_frame_start();
    t0 = cyc;
    keys = '0;
    step(LAT - 1);
    check_held("release_before", 1'b1);
    step(1);
    check_held("release_after", 1'b0);
    step(16);
    nchecks++;
    if (key_code !== 4'd9) begin nerr++; $display("FAIL release_code_hold: got %0d want 9", key_code); end
  endtask

  task automatic test_short_press();
    to_frame_start();
    keys[6] = 1'b1;
    step(2 * FRAME);
    keys = '0;
    step(5 * FRAME);
    check_held("short", 1'b0);
  endtask

  task automatic test_bounce();
    int t0;
    to_frame_start();
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      keys[5] = (i % 2 == 0);
      step(10);
    end
    keys[5] = 1'b1;
    // Last toggle lands in frame 3; frames 4..6 must agree before accept.
    push_exp(t0 + 4 * FRAME + LAT, 4'd5);
    step(130);
    check_held("bounce", 1'b1);
    check_queue_empty("bounce");
    keys = '0;
    to_frame_start();
    step(4 * FRAME);
    check_held("bounce_release", 1'b0);
  endtask

  task automatic test_multi_key();
    int t1;
    to_frame_start();
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    step(5 * FRAME);
    check_held("multi", 1'b0);
    to_frame_start();
    t1 = cyc;
    keys[15] = 1'b0;
    push_exp(t1 + LAT, 4'd0);
    step(LAT + 1);
    check_held("multi_single", 1'b1);
    check_queue_empty("multi");
    keys = '0;
    to_frame_start();
    step(4 * FRAME);
    check_held("multi_release", 1'b0);
  endtask

  task automatic test_reset_mid();
    int t0;
    to_frame_start();
    t0 = cyc;
    keys[3] = 1'b1;
    push_exp(t0 + LAT, 4'd3);
    step(60);
    check_held("rmid_pre", 1'b1);
    check_queue_empty("rmid_pre");
    step(5);
    rst = 1'b1;
    step(1);
    nchecks += 3;
    if (col !== 4'b1110) begin nerr++; $display("FAIL rmid_col: got %b want 1110", col); end
    if (key_code !== 4'd0) begin nerr++; $display("FAIL rmid_code: got %0d want 0", key_code); end
    if (key_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid: got %b want 0", key_valid); end
    check_held("rmid_reset", 1'b0);
    step(1);
    rst = 1'b0;
    push_exp(LAT, 4'd3);
    step(LAT + 2);
    check_held("rmid_reaccept", 1'b1);
    check_queue_empty("rmid");
    keys = '0;
    to_frame_start();
    step(4 * FRAME);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_short_press();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
